// File: rtl/amm_mem_responder.sv
// Avalon-MM burst slave standing in for external memory behind mem_checker.
// Byte-enabled RAM, fixed-latency read pipeline, single-bit read fault injection.
module amm_mem_responder #(
  parameter int AMM_DATA_W  = 128,
  parameter int DATA_B_W    = AMM_DATA_W / 8,
  parameter int AMM_ADDR_W  = 31,
  parameter int AMM_BURST_W = 11,
  parameter int MEM_ADDR_W  = 10,
  parameter int RD_LATENCY  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [AMM_ADDR_W-1:0]         address_i,
  input  logic                          read_i,
  input  logic                          write_i,
  input  logic [AMM_DATA_W-1:0]         writedata_i,
  input  logic [AMM_BURST_W-1:0]        burstcount_i,
  input  logic [DATA_B_W-1:0]           byteenable_i,
  output logic                          waitrequest_o,
  output logic                          readdatavalid_o,
  output logic [AMM_DATA_W-1:0]         readdata_o,
  input  logic                          fault_en_i,
  input  logic [MEM_ADDR_W-1:0]         fault_addr_i,
  input  logic [$clog2(AMM_DATA_W)-1:0] fault_bit_i
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                  state, next_state;
  logic [MEM_ADDR_W-1:0]   cur_addr, mem_idx, req_idx;
  logic [AMM_BURST_W-1:0]  beats_left, req_count;
  logic                    wr_en, rd_issue;
  logic [AMM_DATA_W-1:0]   fault_mask;
  logic [AMM_DATA_W-1:0]   ram [2**MEM_ADDR_W];
  logic                    pipe_valid [RD_LATENCY];
  logic [AMM_DATA_W-1:0]   pipe_data  [RD_LATENCY];
  logic                    unused_addr;

  // Upper address bits alias onto the RAM; a zero burstcount means one beat.
  assign req_idx     = address_i[MEM_ADDR_W-1:0];
  assign req_count   = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
  assign unused_addr = ^address_i[AMM_ADDR_W-1:MEM_ADDR_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (write_i) begin
          if (req_count != AMM_BURST_W'(1)) next_state = WR_BURST;
        end else if (read_i) begin
          next_state = RD_BURST;
        end
      end
      WR_BURST: if (write_i && beats_left == AMM_BURST_W'(1)) next_state = IDLE;
      RD_BURST: if (beats_left == AMM_BURST_W'(1)) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    waitrequest_o = rst_i || (state == RD_BURST);
    wr_en         = 1'b0;
    rd_issue      = 1'b0;
    mem_idx       = cur_addr;
    case (state)
      IDLE: begin
        wr_en   = write_i && !rst_i;
        mem_idx = req_idx;
      end
      WR_BURST: wr_en    = write_i && !rst_i;
      RD_BURST: rd_issue = 1'b1;
      default: ;
    endcase
  end

  // cur_addr always points at the next beat to write or issue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_addr   <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            cur_addr   <= req_idx + MEM_ADDR_W'(1);
            beats_left <= req_count - AMM_BURST_W'(1);
          end else if (read_i) begin
            cur_addr   <= req_idx;
            beats_left <= req_count;
          end
        end
        WR_BURST: begin
          if (write_i) begin
            cur_addr   <= cur_addr + MEM_ADDR_W'(1);
            beats_left <= beats_left - AMM_BURST_W'(1);
          end
        end
        RD_BURST: begin
          cur_addr   <= cur_addr + MEM_ADDR_W'(1);
          beats_left <= beats_left - AMM_BURST_W'(1);
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset so committed writes survive a mid-burst reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < DATA_B_W; k++) begin
        if (byteenable_i[k]) ram[mem_idx][8*k +: 8] <= writedata_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    fault_mask = '0;
    if (fault_en_i && cur_addr == fault_addr_i) fault_mask[fault_bit_i] = 1'b1;
  end

  // Stage 0 captures the issued beat; the fault flip only touches the copy in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_issue;
      pipe_data[0]  <= ram[cur_addr] ^ fault_mask;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign readdatavalid_o = pipe_valid[RD_LATENCY-1];
  assign readdata_o      = pipe_data[RD_LATENCY-1];

endmodule

// File: tb/tb_amm_mem_responder.sv
// Self-checking bench for amm_mem_responder: directed scenarios plus random bursts
// compared against an array memory model and a timed queue of expected read beats.
module tb_amm_mem_responder;

  localparam int DW    = 128;
  localparam int BW    = DW / 8;
  localparam int AW    = 31;
  localparam int CW    = 11;
  localparam int MW    = 10;
  localparam int LAT   = 4;
  localparam int DEPTH = 1 << MW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] address_i;
  logic          read_i, write_i;
  logic [DW-1:0] writedata_i;
  logic [CW-1:0] burstcount_i;
  logic [BW-1:0] byteenable_i;
  logic          waitrequest_o, readdatavalid_o;
  logic [DW-1:0] readdata_o;
  logic          fault_en_i;
  logic [MW-1:0] fault_addr_i;
  logic [6:0]    fault_bit_i;

  amm_mem_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .writedata_i(writedata_i), .burstcount_i(burstcount_i),
    .byteenable_i(byteenable_i), .waitrequest_o(waitrequest_o),
    .readdatavalid_o(readdatavalid_o), .readdata_o(readdata_o),
    .fault_en_i(fault_en_i), .fault_addr_i(fault_addr_i), .fault_bit_i(fault_bit_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    int            due;
    logic [DW-1:0] data;
  } beat_t;

  int            cyc = 0;
  logic [DW-1:0] memModel [DEPTH];
  beat_t         expQ[$];
  logic [DW-1:0] gotQ[$];
  int            busyLo = -1, busyHi = -2;
  int            checkCount = 0, errorCount = 0;
  logic [DW-1:0] wdataBuf [DEPTH];
  logic [BW-1:0] wbeBuf [DEPTH];
  bit            monExpValid;
  int            rdT;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] gotAt(input int i);
    if (i < gotQ.size()) return gotQ[i];
    return 'x;
  endfunction

  // Monitor: expected waitrequest comes from the busy window, read beats from expQ.
  always @(negedge clk_i) begin
    if (rst_i) begin
      checkOutput("rst_waitrequest", DW'(waitrequest_o), DW'(1));
      checkOutput("rst_rdvalid", DW'(readdatavalid_o), DW'(0));
      checkOutput("rst_rddata", readdata_o, '0);
    end else begin
      checkOutput("waitrequest", DW'(waitrequest_o), DW'(cyc >= busyLo && cyc <= busyHi));
      monExpValid = (expQ.size() > 0) && (expQ[0].due == cyc);
      checkOutput("rdvalid", DW'(readdatavalid_o), DW'(monExpValid));
      if (monExpValid) begin
        checkOutput("rddata", readdata_o, expQ[0].data);
        gotQ.push_back(readdata_o);
        void'(expQ.pop_front());
      end
      while (expQ.size() > 0 && expQ[0].due <= cyc) void'(expQ.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input int count, input int maxGap, input bit alsoRead);
    int n = (count == 0) ? 1 : count;
    int idx;
    for (int b = 0; b < n; b++) begin
      if (b > 0 && maxGap > 0) begin
        write_i = 1'b0;
        tick($urandom_range(maxGap, 0));
      end
      write_i      = 1'b1;
      read_i       = (b == 0) && alsoRead;
      address_i    = (b == 0) ? addr : AW'($urandom);
      burstcount_i = (b == 0) ? CW'(count) : CW'($urandom);
      writedata_i  = wdataBuf[b];
      byteenable_i = wbeBuf[b];
      tick(1);
      idx = (int'(addr[MW-1:0]) + b) % DEPTH;
      for (int k = 0; k < BW; k++)
        if (wbeBuf[b][k]) memModel[idx][8*k +: 8] = wdataBuf[b][8*k +: 8];
    end
    write_i = 1'b0;
    read_i  = 1'b0;
  endtask

  task automatic startRead(input logic [AW-1:0] addr, input int count, input bit fen,
                           input int faddr, input int fbit, output int t);
    int n = (count == 0) ? 1 : count;
    int idx;
    beat_t bt;
    read_i       = 1'b1;
    address_i    = addr;
    burstcount_i = CW'(count);
    byteenable_i = BW'($urandom);
    fault_en_i   = fen;
    fault_addr_i = MW'(faddr);
    fault_bit_i  = 7'(fbit);
    tick(1);
    t      = cyc;
    read_i = 1'b0;
    busyLo = t;
    busyHi = t + n - 1;
    for (int b = 0; b < n; b++) begin
      idx      = (int'(addr[MW-1:0]) + b) % DEPTH;
      bt.due   = t + b + LAT;
      bt.data  = memModel[idx];
      if (fen && idx == faddr) bt.data[fbit] = ~bt.data[fbit];
      expQ.push_back(bt);
    end
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input int count, input bit fen,
                        input int faddr, input int fbit);
    int t;
    startRead(addr, count, fen, faddr, fbit, t);
    tick((count == 0) ? 1 : count);
  endtask

  task automatic applyStimulus(input int iterations);
    logic [AW-1:0] addr;
    int count;
    for (int it = 0; it < iterations; it++) begin
      addr  = AW'($urandom);
      count = $urandom_range(8, 0);
      if ($urandom_range(2, 0) != 0) begin
        for (int b = 0; b < 8; b++) begin
          wdataBuf[b] = {$urandom, $urandom, $urandom, $urandom};
          wbeBuf[b]   = BW'($urandom);
        end
        doWrite(addr, count, 2, $urandom_range(3, 0) == 0);
      end else begin
        doRead(addr, count, $urandom_range(1, 0) == 1,
               (int'(addr[MW-1:0]) + $urandom_range(3, 0)) % DEPTH, $urandom_range(DW-1, 0));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0; writedata_i = '0;
    burstcount_i = '0; byteenable_i = '0; fault_en_i = 1'b0; fault_addr_i = '0; fault_bit_i = '0;
    tick(3);
    rst_i = 1'b0;

    // Fill the whole RAM so every later read has a known model value.
    for (int i = 0; i < DEPTH; i++) begin
      wdataBuf[i] = {$urandom, $urandom, $urandom, $urandom};
      wbeBuf[i]   = '1;
    end
    doWrite(0, DEPTH, 0, 1'b0);

    // Single write then read.
    wdataBuf[0] = {16{8'hA5}}; wbeBuf[0] = '1;
    doWrite(5, 1, 0, 1'b0);
    gotQ.delete();
    doRead(5, 1, 1'b0, 0, 0);
    tick(LAT + 2);
    checkOutput("t1_beats", DW'(gotQ.size()), DW'(1));
    checkOutput("t1_data", gotAt(0), {16{8'hA5}});

    // Eight-beat burst with idle gaps between write beats.
    for (int b = 0; b < 8; b++) begin
      wdataBuf[b] = DW'(b); wbeBuf[b] = '1;
    end
    doWrite(100, 8, 3, 1'b0);
    gotQ.delete();
    doRead(100, 8, 1'b0, 0, 0);
    tick(LAT + 2);
    for (int b = 0; b < 8; b++) checkOutput("t2_data", gotAt(b), DW'(b));

    // Byteenable merge.
    wdataBuf[0] = '1; wbeBuf[0] = '1;
    doWrite(0, 1, 0, 1'b0);
    wdataBuf[0] = '0; wbeBuf[0] = BW'(1);
    doWrite(0, 1, 0, 1'b0);
    gotQ.delete();
    doRead(0, 1, 1'b0, 0, 0);
    tick(LAT + 2);
    checkOutput("t3_byteenable", gotAt(0), {{15{8'hFF}}, 8'h00});

    // Wrap past the top of the RAM and upper-address aliasing.
    for (int b = 0; b < 4; b++) begin
      wdataBuf[b] = DW'(b); wbeBuf[b] = '1;
    end
    doWrite(1022, 4, 0, 1'b0);
    gotQ.delete();
    doRead(0, 2, 1'b0, 0, 0);
    doRead(1024, 1, 1'b0, 0, 0);
    tick(LAT + 2);
    checkOutput("t4_wrap0", gotAt(0), DW'(2));
    checkOutput("t4_wrap1", gotAt(1), DW'(3));
    checkOutput("t4_alias", gotAt(2), DW'(2));

    // Fault injection on word 7, bit 3.
    for (int b = 0; b < 3; b++) begin
      wdataBuf[b] = '0; wbeBuf[b] = '1;
    end
    doWrite(6, 3, 0, 1'b0);
    gotQ.delete();
    doRead(6, 3, 1'b1, 7, 3);
    doRead(7, 1, 1'b0, 7, 3);
    tick(LAT + 2);
    checkOutput("t5_beat0", gotAt(0), DW'(0));
    checkOutput("t5_fault", gotAt(1), DW'(8));
    checkOutput("t5_beat2", gotAt(2), DW'(0));
    checkOutput("t5_clean", gotAt(3), DW'(0));

    // Write and read asserted together: the write wins, the read is dropped.
    wdataBuf[0] = {$urandom, $urandom, $urandom, $urandom}; wbeBuf[0] = '1;
    doWrite(200, 1, 0, 1'b1);
    tick(LAT + 2);
    doRead(200, 1, 1'b0, 0, 0);

    // Reset during beat 3 of a 16-beat read.
    for (int b = 0; b < 16; b++) begin
      wdataBuf[b] = {$urandom, $urandom, $urandom, $urandom}; wbeBuf[b] = '1;
    end
    doWrite(300, 16, 0, 1'b0);
    startRead(300, 16, 1'b0, 0, 0, rdT);
    tick(3);
    rst_i = 1'b1;
    expQ.delete();
    busyHi = -2;
    tick(2);
    rst_i = 1'b0;
    gotQ.delete();
    tick(LAT + 4);
    checkOutput("t6_no_stale", DW'(gotQ.size()), DW'(0));
    doRead(300, 16, 1'b0, 0, 0);
    tick(LAT + 2);
    checkOutput("t6_beats", DW'(gotQ.size()), DW'(16));

    applyStimulus(60);
    tick(LAT + 4);
    checkOutput("drain_empty", DW'(expQ.size()), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/amm_mem_responder.md
# amm_mem_responder

- Synthesizable Avalon-MM burst slave that stands in for external memory on the mem_checker memory-side port.
- Accepts the burst writes and burst reads issued by the checker's transmitter and stores data in an internal byte-enabled RAM.
- Returns read data with a fixed pipeline latency; provides a single-bit fault-injection hook so the compare path can be exercised on-chip.
- Sits directly downstream of mem_checker and drives its `mem_waitrequest_i`, `mem_readdatavalid_i` and `mem_readdata_i`.

## Interface

- Clocking and reset: one clock; reset is asynchronous and active-high (`clk_i`, `rst_i`).
- Parameters:
  - `AMM_DATA_W`, default 128: data width.
  - `DATA_B_W`, default `AMM_DATA_W/8`: byteenable width.
  - `AMM_ADDR_W`, default 31: incoming word-address width.
  - `AMM_BURST_W`, default 11: burstcount width.
  - `MEM_ADDR_W`, default 10: RAM depth is 2**MEM_ADDR_W words.
  - `RD_LATENCY`, default 4, range 1..16: cycles from beat issue to readdatavalid.
- Ports:
  - `clk_i` in 1: clock.
  - `rst_i` in 1: async active-high reset.
  - `address_i` in AMM_ADDR_W: word address, sampled on first beat.
  - `read_i` in 1: read request.
  - `write_i` in 1: write beat.
  - `writedata_i` in AMM_DATA_W: write data.
  - `burstcount_i` in AMM_BURST_W: beats in burst, sampled on first beat.
  - `byteenable_i` in DATA_B_W: per-beat byte mask.
  - `waitrequest_o` out 1: stall.
  - `readdatavalid_o` out 1: read beat valid.
  - `readdata_o` out AMM_DATA_W: read data.
  - `fault_en_i` in 1: enable fault injection.
  - `fault_addr_i` in MEM_ADDR_W: faulty word.
  - `fault_bit_i` in $clog2(AMM_DATA_W): bit inverted on read.

## Operation

- FSM states:
  - IDLE
    - `write_i` → latch address and count, write beat 0. If count is 1, stay in IDLE; otherwise go to WR_BURST with beats_left = count−1.
    - `read_i` → latch address and count, go to RD_BURST.
    - `read_i` and `write_i` both high is illegal; treated as write, read dropped.
  - WR_BURST
    - Each cycle with `write_i` high writes one beat at addr+n and decrements beats_left.
    - Cycles with `write_i` low are idle gaps.
    - Return to IDLE after the final beat. `read_i` is ignored.
  - RD_BURST
    - Issues one RAM read per cycle at addr+n, starting the cycle after acceptance.
    - Return to IDLE the cycle after the last beat is issued.
- Burst rules:
  - burstcount 0 is treated as 1.
  - RAM index = (latched address + beat) mod 2**MEM_ADDR_W, i.e. upper address bits ignored; wraps past top of RAM.
  - beats_left is AMM_BURST_W wide; never underflows.
- Writes update only bytes with `byteenable_i[k]`=1. Byteenable is ignored for reads.
- Read pipeline:
  - Shift register of RD_LATENCY stages carrying valid and data; no backpressure.
  - Fault injection: if `fault_en_i` and the issued index equals `fault_addr_i`, bit `fault_bit_i` of that beat is inverted on output only; RAM contents are untouched. Fault inputs are sampled at issue.
- RAM contents are not reset and not cleared by `rst_i`.

## Timing

- Reset values:
  - `waitrequest_o`=1 while `rst_i` is high.
  - `readdatavalid_o`=0, `readdata_o`=0, state=IDLE, pipeline valids cleared.
- `waitrequest_o` after reset:
  - First cycle after release: 0.
  - 0 in IDLE and WR_BURST.
  - 1 throughout RD_BURST: rises the cycle after read acceptance, falls the cycle after the last beat issues.
- Read timing:
  - Read accepted at edge T.
  - Beat n issues at T+1+n.
  - `readdatavalid_o` high at T+1+n+RD_LATENCY with beat n data.
  - Beats are back-to-back with no gaps.
- Next read timing: a new read can be accepted on the first cycle `waitrequest_o` is 0, while earlier beats are still draining. Pipeline ordering is preserved.
- Write-then-read: a write beat at edge T is visible to a read beat issued at T+1 or later.
- Reset mid-burst:
  - Burst aborted and in-flight readdatavalid beats discarded.
  - Writes already committed remain in RAM.

## Test plan

1. Single write then read, RD_LATENCY=4:
   - Stimulus: write addr 5, data 0xA5A5…, be all-ones, count 1; then read addr 5, count 1 accepted at T.
   - Response: `readdatavalid_o` high only at T+5, data 0xA5A5…; `waitrequest_o` high T+1 only.
2. Burst write/read of 8 beats with gaps:
   - Stimulus: write addr 100 with data=beat index, idle gaps between beats; then read 8 from addr 100.
   - Response: 8 contiguous valid beats with data 0..7; `waitrequest_o` high for 8 cycles.
3. Byteenable:
   - Stimulus: write addr 0 all-ones; write addr 0 data 0, be=0x0001; read addr 0.
   - Response: 0xFFFF…FF00.
4. Wrap-around with MEM_ADDR_W=10:
   - Stimulus: write count 4 at addr 1022; read addr 0 count 2.
   - Response: returns beats 2 and 3.
   - Also: address_i=1024 aliases to 0.
5. Fault injection:
   - Stimulus: `fault_en_i`=1, fault_addr 7, bit 3; write 0 to addrs 6..8; read 3 from 6.
   - Response: 0, 0x8, 0. With fault disabled, the re-read of addr 7 returns 0.
6. Reset mid-read:
   - Stimulus: assert `rst_i` during beat 3 of a 16-beat read.
   - Response: `readdatavalid_o` 0 immediately and stays 0 after release; `waitrequest_o` 1 during reset, 0 after; a subsequent read returns the previously written data.
